// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared encodings and constants for the data memory arbiter
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [63:0] WORD_BYTES = 64'd8;
    localparam logic [63:0] DATA_START = 64'h0000_0000_1000_0000;

endpackage

// File: rtl/dmem_burst_gen.sv
// rtl/dmem_burst_gen.sv - latches burst base/length, produces beat address and last-beat flag
module dmem_burst_gen
    import dmem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        advance,
    input  logic [63:0] base,
    input  logic [4:0]  len,
    output logic [63:0] beat_addr,
    output logic        last_beat
);

    logic [63:0] base_q, base_d;
    logic [4:0]  len_q, len_d;
    logic [4:0]  cnt_q, cnt_d;

    always_comb begin
        base_d = base_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        if (load) begin
            base_d = base;
            len_d  = len;
            cnt_d  = '0;
        end else if (advance) begin
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
        end else begin
            base_q <= base_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
        end
    end

    // Address arithmetic wraps at 64 bits by construction.
    assign beat_addr = base_q + 64'(cnt_q) * WORD_BYTES;
    assign last_beat = (cnt_q == len_q - 5'd1);

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/DMA arbiter for the single-ported data memory
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int MAX_LEN  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic [63:0] c_addr,
    input  logic [63:0] c_wdata,
    input  logic        c_word_we,
    input  logic        c_byte_we,
    output logic        c_ready,
    output logic [63:0] c_rdata,
    input  logic        d_start,
    input  logic [63:0] d_addr,
    input  logic [4:0]  d_len,
    input  logic        d_we,
    input  logic [63:0] d_wdata,
    output logic        d_accept,
    output logic        d_beat,
    output logic [63:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        mem_word_we,
    output logic        mem_byte_we,
    input  logic [63:0] mem_rdata
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              serve_core;
    logic              load, advance;
    logic [63:0]       beat_addr;
    logic              last_beat;
    logic              bad_req;

    dmem_burst_gen u_burst_gen (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (advance),
        .base      (d_addr),
        .len       (d_len),
        .beat_addr (beat_addr),
        .last_beat (last_beat)
    );

    assign c_rdata = mem_rdata;
    assign d_rdata = mem_rdata;
    assign bad_req = (d_len == 5'd0) || (int'(d_len) > MAX_LEN) || (d_addr[2:0] != 3'd0);

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        we_d        = we_q;
        err_d       = err_q;
        serve_core  = 1'b0;
        load        = 1'b0;
        advance     = 1'b0;
        c_ready     = 1'b0;
        d_accept    = 1'b0;
        d_beat      = 1'b0;
        d_done      = 1'b0;
        d_err       = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        mem_word_we = 1'b0;
        mem_byte_we = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (c_req && !(d_start && wait_cnt_q == WAIT_MAX)) begin
                    serve_core = 1'b1;
                end else if (d_start) begin
                    d_accept = 1'b1;
                    state_d  = DONE;
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        err_d      = 1'b0;
                        we_d       = d_we;
                        load       = 1'b1;
                        wait_cnt_d = '0;
                        state_d    = BURST;
                    end
                end
            end
            BURST: begin
                advance     = 1'b1;
                d_beat      = 1'b1;
                mem_addr    = beat_addr;
                mem_wdata   = d_wdata;
                mem_word_we = we_q;
                if (last_beat) state_d = DONE;
            end
            DONE: begin
                d_done     = 1'b1;
                d_err      = err_q;
                state_d    = IDLE;
                serve_core = c_req;
            end
            default: state_d = IDLE;
        endcase

        // A pending DMA start accrues credit each cycle the core takes the memory.
        if (serve_core) begin
            c_ready     = 1'b1;
            mem_addr    = c_addr;
            mem_wdata   = c_wdata;
            mem_word_we = c_word_we;
            mem_byte_we = c_byte_we;
            if (d_start && wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
        if (!d_start) wait_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            we_q       <= we_d;
            err_q      <= err_d;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        c_req;
    logic [63:0] c_addr;
    logic [63:0] c_wdata;
    logic        c_word_we;
    logic        c_byte_we;
    logic        c_ready;
    logic [63:0] c_rdata;
    logic        d_start;
    logic [63:0] d_addr;
    logic [4:0]  d_len;
    logic        d_we;
    logic [63:0] d_wdata;
    logic        d_accept;
    logic        d_beat;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        mem_word_we;
    logic        mem_byte_we;
    logic [63:0] mem_rdata;

    int vectors = 0;
    int errors  = 0;

    localparam logic [63:0] BASE = 64'h0000_0000_1000_0000;
    localparam logic [63:0] WA   = 64'hAAAA_5555_1234_0001;
    localparam logic [63:0] WB   = 64'hBBBB_6666_5678_0002;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_word_we(c_word_we), .c_byte_we(c_byte_we),
        .c_ready(c_ready), .c_rdata(c_rdata),
        .d_start(d_start), .d_addr(d_addr), .d_len(d_len), .d_we(d_we),
        .d_wdata(d_wdata), .d_accept(d_accept), .d_beat(d_beat),
        .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_word_we(mem_word_we), .mem_byte_we(mem_byte_we),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] init_word(input int i);
        return 64'h0123_4567_89AB_CD00 + 64'(i);
    endfunction

    // Small data_mem model: combinational read, negedge write, preloaded in reset.
    logic [63:0] mem [0:31];
    assign mem_rdata = mem[mem_addr[7:3]];
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_word(i);
        end else if (mem_word_we) begin
            mem[mem_addr[7:3]] <= mem_wdata;
        end else if (mem_byte_we) begin
            mem[mem_addr[7:3]][8*mem_addr[2:0] +: 8] <= mem_wdata[7:0];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset = 1'b1; c_req = 1'b0; c_addr = '0; c_wdata = '0; c_word_we = 1'b0;
        c_byte_we = 1'b0; d_start = 1'b0; d_addr = '0; d_len = '0; d_we = 1'b0; d_wdata = '0;
        tick(); tick();
        settle();
        chk1("rst_c_ready", c_ready, 1'b0);
        chk1("rst_d_accept", d_accept, 1'b0);
        chk1("rst_d_beat", d_beat, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk1("rst_mem_word_we", mem_word_we, 1'b0);
        reset = 1'b0;
        tick();

        // Core-only read.
        c_req = 1'b1; c_addr = BASE + 64'd8;
        settle();
        chk1("core_ready", c_ready, 1'b1);
        chk("core_rdata", c_rdata, init_word(1));
        chk("core_mem_addr", mem_addr, BASE + 64'd8);
        chk1("core_no_accept", d_accept, 1'b0);
        chk1("core_no_beat", d_beat, 1'b0);
        chk1("core_no_we", mem_word_we, 1'b0);
        tick();
        c_req = 1'b0;

        // DMA read burst of 4.
        d_start = 1'b1; d_addr = BASE; d_len = 5'd4; d_we = 1'b0;
        settle();
        chk1("rd_accept", d_accept, 1'b1);
        chk1("rd_accept_no_beat", d_beat, 1'b0);
        tick();
        d_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk1("rd_beat", d_beat, 1'b1);
            chk("rd_addr", mem_addr, BASE + 64'(8 * i));
            chk("rd_data", d_rdata, init_word(i));
            chk1("rd_no_done", d_done, 1'b0);
            chk1("rd_no_we", mem_word_we, 1'b0);
            tick();
        end
        settle();
        chk1("rd_done", d_done, 1'b1);
        chk1("rd_err", d_err, 1'b0);
        chk1("rd_done_no_beat", d_beat, 1'b0);
        tick();

        // DMA write burst of 2 at BASE+0x40, then read back through the core.
        d_start = 1'b1; d_addr = BASE + 64'h40; d_len = 5'd2; d_we = 1'b1;
        settle();
        chk1("wr_accept", d_accept, 1'b1);
        tick();
        d_start = 1'b0; d_wdata = WA;
        settle();
        chk1("wr_beat0_we", mem_word_we, 1'b1);
        chk1("wr_beat0_bwe", mem_byte_we, 1'b0);
        chk("wr_beat0_addr", mem_addr, BASE + 64'h40);
        tick();
        d_wdata = WB;
        settle();
        chk1("wr_beat1_we", mem_word_we, 1'b1);
        chk("wr_beat1_addr", mem_addr, BASE + 64'h48);
        tick();
        d_wdata = '0;
        settle();
        chk1("wr_done", d_done, 1'b1);
        chk1("wr_done_we", mem_word_we, 1'b0);
        tick();
        c_req = 1'b1; c_addr = BASE + 64'h40;
        settle();
        chk("wr_readback_a", c_rdata, WA);
        tick();
        c_addr = BASE + 64'h48;
        settle();
        chk("wr_readback_b", c_rdata, WB);
        tick();

        // Core byte write with both enables passes both through.
        c_addr = BASE + 64'h50; c_wdata = 64'h0000_0000_0000_00EE; c_word_we = 1'b1; c_byte_we = 1'b1;
        settle();
        chk1("core_both_word", mem_word_we, 1'b1);
        chk1("core_both_byte", mem_byte_we, 1'b1);
        chk("core_wdata", mem_wdata, 64'h0000_0000_0000_00EE);
        tick();
        c_word_we = 1'b0; c_byte_we = 1'b0;

        // Starvation guard: core wins 4 times, DMA wins the 5th.
        c_addr = BASE; d_start = 1'b1; d_addr = BASE; d_len = 5'd1; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk1("starve_core_ready", c_ready, 1'b1);
            chk1("starve_no_accept", d_accept, 1'b0);
            tick();
        end
        settle();
        chk1("starve_accept", d_accept, 1'b1);
        chk1("starve_core_blocked", c_ready, 1'b0);
        tick();
        d_start = 1'b0;
        settle();
        chk1("starve_beat", d_beat, 1'b1);
        chk1("starve_burst_stall", c_ready, 1'b0);
        tick();
        settle();
        chk1("starve_done", d_done, 1'b1);
        chk1("starve_done_core", c_ready, 1'b1);
        chk("starve_done_addr", mem_addr, BASE);
        tick();
        c_req = 1'b0;

        // Rejects: zero length, over-length, misaligned.
        for (int r = 0; r < 3; r++) begin
            d_start = 1'b1;
            d_addr  = (r == 2) ? BASE + 64'd4 : BASE;
            d_len   = (r == 0) ? 5'd0 : (r == 1) ? 5'd17 : 5'd2;
            settle();
            chk1("rej_accept", d_accept, 1'b1);
            chk1("rej_accept_we", mem_word_we, 1'b0);
            tick();
            d_start = 1'b0;
            settle();
            chk1("rej_done", d_done, 1'b1);
            chk1("rej_err", d_err, 1'b1);
            chk1("rej_no_beat", d_beat, 1'b0);
            chk1("rej_no_we", mem_word_we, 1'b0);
            tick();
        end

        // Maximum-length burst is legal.
        d_start = 1'b1; d_addr = BASE; d_len = 5'd16;
        settle();
        chk1("max_accept", d_accept, 1'b1);
        tick();
        d_start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk1("max_beat", d_beat, 1'b1);
            tick();
        end
        settle();
        chk1("max_done", d_done, 1'b1);
        chk1("max_err", d_err, 1'b0);
        tick();

        // Reset during beat 1 of a len-8 burst.
        d_start = 1'b1; d_addr = BASE; d_len = 5'd8;
        tick();
        d_start = 1'b0;
        tick();
        settle();
        chk1("rstb_beat1", d_beat, 1'b1);
        chk("rstb_beat1_addr", mem_addr, BASE + 64'd8);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        chk1("rstb_no_beat", d_beat, 1'b0);
        chk1("rstb_no_done", d_done, 1'b0);
        chk1("rstb_no_accept", d_accept, 1'b0);
        chk("rstb_mem_addr", mem_addr, 64'd0);
        tick();
        settle();
        chk1("rstb_still_idle", d_done, 1'b0);
        d_start = 1'b1; d_addr = BASE + 64'h10; d_len = 5'd2;
        settle();
        chk1("rstb_new_accept", d_accept, 1'b1);
        tick();
        d_start = 1'b0;
        settle();
        chk("rstb_new_b0", d_rdata, init_word(2));
        tick();
        settle();
        chk("rstb_new_b1", d_rdata, init_word(3));
        tick();
        settle();
        chk1("rstb_new_done", d_done, 1'b1);
        chk1("rstb_new_err", d_err, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
